// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {inst, pc} entries with flush; the head is held
// in a register so it keeps its last value while the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  localparam int         PTR_W    = $clog2(DEPTH),
  localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_push,
  input  fetch_entry_t       i_push_data,
  input  logic               i_pop,
  output fetch_entry_t       o_head,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_valid
);

  fetch_entry_t r_mem [DEPTH];

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  fetch_entry_t     r_head;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [PTR_W-1:0] w_rd_next;
  logic [CNT_W-1:0] w_cnt_next;
  fetch_entry_t     w_head_next;

  always_comb begin
    w_pop_ok   = i_pop && (r_count != '0);
    w_push_ok  = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop_ok);
    w_rd_next  = r_rd_ptr + PTR_W'(w_pop_ok);
    w_cnt_next = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    w_head_next = r_head;
    // The new head is the entry being written this cycle when no older entry remains.
    if (w_cnt_next != '0) begin
      if (w_push_ok && (r_wr_ptr == w_rd_next)) begin
        w_head_next = i_push_data;
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '{inst: NOP_INST, pc: RESET_PC};
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_ok);
      r_count  <= w_cnt_next;
      r_head   <= w_head_next;
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;
  assign o_valid = (r_count != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one-outstanding word fetches
// and buffers returned instructions ahead of the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_inc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_tag_pc;
  logic        r_outstanding;
  logic        r_drop;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_inflight;
  logic             w_issue;
  logic             w_accept;
  logic             w_resp;
  logic             w_push;
  logic             w_pop;
  fetch_entry_t     w_push_data;
  fetch_entry_t     w_head;

  // Queue slots already committed plus the one in flight must leave room for the next word.
  assign w_inflight = {1'b0, w_count} + (CNT_W + 1)'(r_outstanding);
  assign w_issue    = !rst && !redirect
                      && (!r_outstanding || imem_rvalid)
                      && (w_inflight < (CNT_W + 1)'(DEPTH));
  assign w_accept   = w_issue && imem_gnt;
  assign w_resp     = imem_rvalid && r_outstanding;
  assign w_push     = w_resp && !r_drop && !redirect;
  assign w_pop      = id_valid && id_ready;

  assign w_push_data = '{inst: imem_rdata, pc: r_tag_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_tag_pc      <= RESET_PC;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc & ~32'h3;
      // A response still in flight belongs to the old path and must be thrown away.
      if (r_outstanding) begin
        if (imem_rvalid) begin
          r_outstanding <= 1'b0;
          r_drop        <= 1'b0;
        end else begin
          r_drop <= 1'b1;
        end
      end
    end else begin
      if (w_accept) begin
        r_outstanding <= 1'b1;
        r_tag_pc      <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + PC_STEP;
      end else if (w_resp) begin
        r_outstanding <= 1'b0;
      end
      if (w_resp) begin
        r_drop <= 1'b0;
      end
    end
  end

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_valid     (id_valid)
  );

  assign imem_req  = w_issue;
  assign imem_addr = r_fetch_pc;
  assign id_inst   = w_head.inst;
  assign id_pc     = w_head.pc;
  assign id_pc_inc = w_head.pc + PC_STEP;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues word fetches to the shared instruction/data memory port through a request/grant handshake. Returned instructions are buffered in a small queue so that memory-port contention and decode stalls are decoupled. On a resolved branch/jump redirect it flushes all in-flight and buffered work and restarts at the new PC.

## Interface
Parameters:
- DEPTH, 4, instruction queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held with a stable imem_addr until granted
- imem_addr  out  32  word-aligned fetch address (bits[1:0] = 0)
- imem_gnt  in  1  port granted this cycle; request accepted when imem_req & imem_gnt
- imem_rvalid  in  1  read data valid for the single outstanding request
- imem_rdata  in  32  instruction word
- id_valid  out  1  queue head is valid
- id_ready  in  1  IF/ID accepts the head; pop on id_valid & id_ready
- id_inst  out  32  head instruction
- id_pc  out  32  PC of head instruction
- id_pc_inc  out  32  id_pc + 4, modulo 2^32
- redirect  in  1  branch/jump taken; flush and restart
- redirect_pc  in  32  new fetch PC; bits[1:0] are forced to 0

## Operation
- State: fetch_pc (next address to request), outstanding flag plus drop flag, and queue {inst, pc} with count 0..DEPTH.
- Issue rule: assert imem_req when no redirect is active this cycle, and (outstanding==0 or imem_rvalid this cycle), and count + outstanding < DEPTH, where count and outstanding are the registered values. At most one request is outstanding.
- On accept (req & gnt): outstanding←1, the captured pc is tagged with the request, and fetch_pc←fetch_pc+4 (wraps at 2^32).
- Response: imem_rvalid with outstanding==1. If drop==0, push {imem_rdata, tagged pc}. If drop==1, discard the data and clear drop. In both cases outstanding clears.
- Ungranted request: imem_req and imem_addr stay stable across cycles until granted, unless a redirect arrives.
- Redirect (highest priority):
  - queue is cleared (count←0) and any same-cycle pop is ignored;
  - fetch_pc←{redirect_pc[31:2],2'b00};
  - imem_req is deasserted this cycle; a pending ungranted request is withdrawn;
  - if a request is outstanding and its rvalid does not arrive this cycle, drop←1;
  - an rvalid arriving in the redirect cycle is discarded.
- Queue full: no new request. A push and a pop in the same cycle are legal at any count. Overflow is impossible by construction of the issue rule.
- Empty queue: id_valid=0, and id_inst/id_pc hold their last values.
- rvalid while outstanding==0 is a protocol error; it is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=RESET_PC, id_pc_inc=RESET_PC+4; count=0, outstanding=0, drop=0, fetch_pc=RESET_PC.
- The first imem_req rises in the first cycle after rst deasserts.
- Queue writes are registered. An instruction whose rvalid arrives in cycle t is presented with id_valid=1 in cycle t+1. Minimum latency from accepted request to id_valid is 2 cycles.
- Throughput: with gnt always high, rvalid exactly one cycle after grant, and id_ready high, the unit sustains 1 instruction/cycle.
- After a redirect in cycle r, the earliest new request is in cycle r+1. If the drop flag was set, the earliest new request is the cycle of the dropped rvalid.
- rst asserted mid-operation: all state returns to reset values on the next edge. Pending requests and any rvalid in that cycle are abandoned.

## Structure
- Shared package (fetch_pkg):
  - NOP_INST = 32'h0000_0013
  - PC_STEP = 32'd4
  - typedef fetch_entry_t {inst[31:0], pc[31:0]}
  - default RESET_PC
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, DEPTH entries. Supports push, pop, flush and count, with flush taking priority over push and pop.
- The top level holds the PC, the outstanding/drop flags and the issue logic.

## Test plan
- Reset and streaming: with gnt=1, rvalid one cycle after grant and id_ready=1, the bench must see imem_addr 0, 4, 8, 12… on consecutive cycles and id_pc 0, 4, 8… from cycle 3 onward, with id_pc_inc = id_pc+4.
- Backpressure: hold id_ready=0 with DEPTH=4. After exactly 4 pushes imem_req must stay 0. Raising id_ready for one cycle must produce exactly one new request at the next sequential address.
- Grant stall: hold gnt=0 for 5 cycles with imem_addr=0x10. imem_req must stay 1 and imem_addr must stay 0x10 throughout, with no fetch_pc advance.
- Redirect with outstanding request: redirect_pc=0x103 while the request for 0x20 is outstanding. The late rvalid must be dropped, the queue must be empty, and the next request address must be 0x100.
- Simultaneous redirect, pop and rvalid in one cycle: the next cycle must have id_valid=0 and the returned data must be absent from the queue. Then a fetch at the redirect target must follow.
- PC wrap: redirect to 0xFFFF_FFFC. The bench must see id_pc_inc=0x0000_0000 and the next request address 0x0000_0000.
